// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel converter with sync-marked word boundaries and a
// one-deep output register. Define S2P_PARITY_EN to append an even-parity bit per word.
module serial_to_parallel #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             frame_err,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
`ifdef S2P_PARITY_EN
   localparam logic [1:0] PARITY = 2'd2;
`endif

   logic [1:0]       state, state_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] shreg, shreg_next;
   logic [WIDTH-1:0] word;
   logic             complete;
   logic             restart;
`ifdef S2P_PARITY_EN
   logic             perr_next;
   logic             perr_q;
`endif

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      shreg_next = shreg;
      word       = shreg;
      complete   = 1'b0;
      restart    = 1'b0;
`ifdef S2P_PARITY_EN
      perr_next  = 1'b0;
`endif
      if (din_valid) begin
         if (sync) begin
            // A sync always begins a new word; outside IDLE it abandons the partial one.
            restart       = (state != IDLE);
            state_next    = SHIFT;
            cnt_next      = CW'(1);
            shreg_next    = '0;
            shreg_next[0] = din;
         end else begin
            case (state)
               IDLE: ;
               SHIFT: begin
                  for (int i = 0; i < WIDTH; i++) begin
                     if (cnt == CW'(i)) shreg_next[i] = din;
                  end
                  word = shreg_next;
                  if (cnt == CW'(WIDTH - 1)) begin
`ifdef S2P_PARITY_EN
                     state_next = PARITY;
                     cnt_next   = CW'(WIDTH);
`else
                     state_next = IDLE;
                     cnt_next   = '0;
                     complete   = 1'b1;
`endif
                  end else begin
                     cnt_next = cnt + CW'(1);
                  end
               end
`ifdef S2P_PARITY_EN
               PARITY: begin
                  // Even parity: data bits XOR parity bit must be 0.
                  complete   = 1'b1;
                  perr_next  = ^{shreg, din};
                  state_next = IDLE;
                  cnt_next   = '0;
               end
`endif
               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
`ifdef S2P_PARITY_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         shreg     <= shreg_next;
         frame_err <= restart;
         overrun   <= 1'b0;
         if (complete) begin
            // A full output register that is not being drained drops the new word.
            if (!dout_valid || dout_ready) begin
               dout       <= word;
               dout_valid <= 1'b1;
`ifdef S2P_PARITY_EN
               perr_q     <= perr_next;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

`ifdef S2P_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
